// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory sitting behind the CPU MEM-stage
// load/store port, with a configurable access latency.
//
// Handshake (valid/ready): while ready_o=1 the block is IDLE, and req_i=1 at
// a rising edge is an accepted request. On that edge we_i/addr_i/wdata_i are
// captured. ack_o then pulses for exactly one cycle, LATENCY cycles after
// acceptance. stall_o holds the pipeline from the accept cycle until the ack
// cycle. Inputs are ignored between acceptance and ack.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i        request valid
//   we_i         1 = store, 0 = load
//   addr_i       byte address; word index is addr[ADDR_W+1:2]
//   wdata_i      store data
//   ready_o      idle, able to accept a request
//   stall_o      freeze the upstream pipeline registers this cycle
//   ack_o        one-cycle completion pulse
//   rdata_o      load data, valid with ack_o on a load, held until next load
//   err_o        access fault (misaligned or out of range), pulses with ack_o
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 RESP), for observation
module dmem_responder #(
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 5,
   parameter int LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        stall_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam bit         ONE_CYCLE = (LATENCY == 1);
   localparam logic [3:0] CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] mem [DEPTH];

   // With LATENCY=1 the access completes on the accept edge itself, before the
   // latch registers hold anything, so the access uses the live inputs then.
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        cur_fault;
   logic [ADDR_W-1:0] cur_idx;
   logic        go_resp;

   always_comb begin
      cur_we    = lat_we;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      if (state == IDLE) begin
         cur_we    = we_i;
         cur_addr  = addr_i;
         cur_wdata = wdata_i;
      end
      cur_idx   = cur_addr[ADDR_W+1:2];
      cur_fault = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
      // True on the edge that moves the FSM into RESP.
      go_resp   = (state == IDLE && req_i && ONE_CYCLE) ||
                  (state == WAIT && cnt == 4'd0);
   end

   assign stall_o     = (req_i && state == IDLE) || (state == WAIT);
   assign dbg_state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= 32'd0;
         ready_o   <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  lat_we    <= we_i;
                  lat_addr  <= addr_i;
                  lat_wdata <= wdata_i;
                  ready_o   <= 1'b0;
                  if (ONE_CYCLE) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP: begin
               state   <= IDLE;
               ready_o <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_o <= 1'b1;
            end
         endcase
         if (go_resp) begin
            ack_o <= 1'b1;
            err_o <= cur_fault;
            // Stores leave rdata_o untouched; faulted loads return zero.
            if (!cur_we) rdata_o <= cur_fault ? 32'd0 : mem[cur_idx];
         end
      end
   end

   // Array is never reset; a reset on the commit edge discards the store.
   always_ff @(posedge clk_i) begin
      if (!rst_i && go_resp && cur_we && !cur_fault) mem[cur_idx] <= cur_wdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  bit          sel;  // 0 = LATENCY 4 instance, 1 = LATENCY 1 instance

  logic        req4, ready4, stall4, ack4, err4;
  logic [31:0] rdata4;
  logic [1:0]  st4;
  logic        req1, ready1, stall1, ack1, err1;
  logic [31:0] rdata1;
  logic [1:0]  st1;

  logic        ready_m, stall_m, ack_m, err_m;
  logic [31:0] rdata_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req4    = req & ~sel;
  assign req1    = req & sel;
  assign ready_m = sel ? ready1 : ready4;
  assign stall_m = sel ? stall1 : stall4;
  assign ack_m   = sel ? ack1   : ack4;
  assign err_m   = sel ? err1   : err4;
  assign rdata_m = sel ? rdata1 : rdata4;

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready4), .stall_o(stall4), .ack_o(ack4),
    .rdata_o(rdata4), .err_o(err4), .dbg_state_o(st4)
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready1), .stall_o(stall1), .ack_o(ack1),
    .rdata_o(rdata1), .err_o(err1), .dbg_state_o(st1)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;  // used for loads only
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mdl[32];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_val(input int i);
    return {8'hA5, 8'(i), 16'h5A5A};
  endfunction

  // One full transaction on the selected instance; called just after an edge
  // with that instance idle.
  task automatic txn(input bit s, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit churn,
                     output logic [31:0] rd, output logic er);
    int n;
    int stall_bad;
    int exp_lat;
    exp_lat = s ? 1 : 4;
    sel = s;
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    check("accept_stall", stall_m, 1);
    check("accept_ready", ready_m, 1);
    tick();
    req = 1'b0;
    if (churn) begin
      we = ~w; addr = a ^ 32'h4; wdata = $urandom;
    end
    n = 1;
    stall_bad = 0;
    while (ack_m !== 1'b1 && n < 40) begin
      if (stall_m !== 1'b1) stall_bad++;
      tick();
      n++;
    end
    check("latency", n, exp_lat);
    check("wait_stall_bad", stall_bad, 0);
    check("ack_stall", stall_m, 0);
    check("ack_ready", ready_m, 0);
    rd = rdata_m;
    er = err_m;
    tick();
    check("post_ack", ack_m, 0);
    check("post_ready", ready_m, 1);
    if (churn) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("churn_single_ack", ack_m, 0);
      end
    end
    we = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      check("rst_ready", ready_m, 1);
      check("rst_ack",   ack_m,   0);
      check("rst_err",   err_m,   0);
      check("rst_rdata", rdata_m, 0);
      check("rst_stall", stall_m, 0);
    end
    sel = 1'b0;
    tick();

    // Fill every word of the LATENCY 4 instance
    for (int i = 0; i < 32; i++) begin
      txn(0, 1, 32'(i * 4), init_val(i), 0, rd, er);
      mdl[i] = init_val(i);
    end
    last_rd = 32'd0;

    // Table-driven transactions
    vecs.push_back('{1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          0});
    vecs.push_back('{0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  0});
    vecs.push_back('{0, 32'h0000_0006, 32'h0,         32'h0,          1});
    vecs.push_back('{1, 32'h0000_0080, 32'hBAD0_BAD0, 32'h0,          1});
    vecs.push_back('{0, 32'h0000_0000, 32'h0,         32'hA500_5A5A,  0});
    vecs.push_back('{1, 32'h0000_007C, 32'h0F0F_0F0F, 32'h0,          0});
    vecs.push_back('{0, 32'h0000_007C, 32'h0,         32'h0F0F_0F0F,  0});
    vecs.push_back('{1, 32'h0000_0004, 32'h1357_9BDF, 32'h0,          0});
    vecs.push_back('{0, 32'h8000_0000, 32'h0,         32'h0,          1});
    vecs.push_back('{1, 32'h0000_0002, 32'h7777_7777, 32'h0,          1});
    vecs.push_back('{0, 32'h0000_0004, 32'h0,         32'h1357_9BDF,  0});
    foreach (vecs[i]) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      exp_rd = vecs[i].we ? last_rd : vecs[i].exp_rd;
      check($sformatf("vec%0d_rdata", i), rd, exp_rd);
      if (!vecs[i].we) last_rd = vecs[i].exp_rd;
      if (vecs[i].we && !vecs[i].exp_err) mdl[vecs[i].addr[6:2]] = vecs[i].wdata;
    end

    // Faulted stores must have left every word intact
    for (int i = 0; i < 32; i++) begin
      txn(0, 0, 32'(i * 4), 32'd0, 0, rd, er);
      check($sformatf("sweep%0d", i), rd, mdl[i]);
    end

    // Reset in the second WAIT cycle of a store to 0x8
    sel = 1'b0;
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h1234;
    tick();
    req = 1'b0;
    tick();
    check("midrst_in_wait", stall_m, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", ready_m, 1);
    check("midrst_ack",   ack_m,   0);
    check("midrst_stall", stall_m, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_ack", ack_m, 0);
    end
    txn(0, 0, 32'h8, 32'd0, 0, rd, er);
    check("midrst_old_value", rd, mdl[2]);

    // Input churn after acceptance
    txn(0, 1, 32'h14, 32'hCAFE_F00D, 1, rd, er);
    check("churn_err", er, 0);
    mdl[5] = 32'hCAFE_F00D;
    txn(0, 0, 32'h14, 32'd0, 0, rd, er);
    check("churn_word", rd, 32'hCAFE_F00D);
    txn(0, 0, 32'h18, 32'd0, 0, rd, er);
    check("churn_neighbour", rd, mdl[6]);

    // LATENCY 1, back-to-back loads with req held high
    txn(1, 1, 32'h0, 32'h11, 0, rd, er);
    txn(1, 1, 32'h4, 32'h22, 0, rd, er);
    sel = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h0;
    #1;
    check("b2b_c1_stall", stall_m, 1);
    check("b2b_c1_ack",   ack_m,   0);
    tick();
    check("b2b_c2_ack",   ack_m,   1);
    check("b2b_c2_rdata", rdata_m, 32'h11);
    check("b2b_c2_stall", stall_m, 0);
    addr = 32'h4;
    #1;
    tick();
    check("b2b_c3_ack",   ack_m,   0);
    check("b2b_c3_stall", stall_m, 1);
    tick();
    check("b2b_c4_ack",   ack_m,   1);
    check("b2b_c4_rdata", rdata_m, 32'h22);
    check("b2b_c4_err",   err_m,   0);
    req = 1'b0;
    #1;
    check("b2b_c4_stall", stall_m, 0);
    tick();
    check("b2b_c5_ack",   ack_m,   0);
    check("b2b_c5_stall", stall_m, 0);

    // LATENCY 1 fault
    txn(1, 0, 32'h6, 32'd0, 0, rd, er);
    check("lat1_fault_err",   er, 1);
    check("lat1_fault_rdata", rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
